// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: access codes, FSM states, error codes, regions.
// No logic of its own; imported by the controller and its byte-lane helper.
package data_mem_ctrl_pkg;

  localparam int DATA_W    = 48;
  localparam int NUM_LANES = 6;

  typedef enum logic [2:0] {
    MC_NONE     = 3'b000,
    MC_RD_WORD  = 3'b001,
    MC_RD_BYTEU = 3'b010,
    MC_RD_BYTES = 3'b011,
    MC_WR_WORD  = 3'b100,
    MC_WR_BYTE  = 3'b101,
    MC_RSV6     = 3'b110,
    MC_RSV7     = 3'b111
  } memCtrl_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RMW_RD  = 3'd2,
    RMW_WR  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } memState_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Upper 32 address bits select the region.
  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] IO_BASE  = 32'h0000_0001;

  function automatic logic isByteCode(input memCtrl_e code);
    return (code == MC_RD_BYTEU) || (code == MC_RD_BYTES) || (code == MC_WR_BYTE);
  endfunction

  function automatic logic isWordCode(input memCtrl_e code);
    return (code == MC_RD_WORD) || (code == MC_WR_WORD);
  endfunction

  function automatic logic isWriteCode(input memCtrl_e code);
    return (code == MC_WR_WORD) || (code == MC_WR_BYTE);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_byte_lane.sv
// Byte-lane extract with zero/sign extension, and byte merge into a 48-bit word.
// Purely combinational; lanes 6/7 extract as zero and leave the word unmerged.
module byte_lane
  import data_mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        lane,
  input  logic              signExt,
  input  logic [7:0]        wrByte,
  output logic [DATA_W-1:0] rdExt,
  output logic [DATA_W-1:0] merged
);

  logic [7:0] laneByte;

  always_comb begin
    laneByte = 8'h00;
    merged   = word;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane == 3'(k)) begin
        laneByte        = word[8*k +: 8];
        merged[8*k +: 8] = wrByte;
      end
    end
  end

  assign rdExt = {{(DATA_W-8){signExt & laneByte[7]}}, laneByte};

endmodule

// File: rtl/data_mem_ctrl.sv
// M-stage data-memory controller: decodes CPU accesses, runs backend req/ack, RMW for byte stores.
// Stalls the CPU from the request cycle until the one-cycle RESP; backend may hold ack off up to TIMEOUT_CYC.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15,
  parameter int WADDR_W     = 13
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               MemWriteM,
  input  logic [47:0]        ALUOutM,
  input  logic [47:0]        WriteDataM,
  input  logic [2:0]         MemoryControl,
  output logic [47:0]        ReadDataM,
  output logic               StallMem,
  output logic               BusErr,
  output logic [1:0]         ErrCode,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [47:0]        mem_wdata,
  input  logic [47:0]        mem_rdata,
  input  logic               mem_ack
);

  memState_e          state, stateNxt;
  memCtrl_e           code, codeR;
  logic [3:0]         waitCnt;
  logic [WADDR_W-1:0] addrR;
  logic [2:0]         laneR;
  logic               selR;
  logic [47:0]        wdataR;
  logic [7:0]         byteR;
  logic [47:0]        rdR;
  logic [1:0]         errR, errNxt;
  logic               errPend;

  logic [31:0] region;
  logic [2:0]  lane;
  logic        decErr, alignErr, waitState, expire, tmo;
  logic        latchReq, cntClr, cntInc, errSet, rdCap, rdClr, mergeCap;
  logic [47:0] laneRd, laneMerged;

  assign code   = memCtrl_e'(MemoryControl);
  assign region = ALUOutM[47:16];
  assign lane   = ALUOutM[2:0];
  assign decErr = (region != RAM_BASE) && (region != IO_BASE);

  assign alignErr = (code == MC_RSV6) || (code == MC_RSV7)
                 || (MemWriteM != isWriteCode(code))
                 || (isByteCode(code) && (lane > 3'(NUM_LANES-1)))
                 || (isWordCode(code) && (lane != 3'd0));

  assign waitState = (state == RD_WAIT) || (state == RMW_RD)
                  || (state == RMW_WR)  || (state == WR_WAIT);
  // Ack on the final allowed cycle wins over the timeout.
  assign expire = (waitCnt == 4'(TIMEOUT_CYC-1));
  assign tmo    = waitState && !mem_ack && expire;

  always_comb begin
    stateNxt = state;
    latchReq = 1'b0;
    cntClr   = 1'b0;
    cntInc   = 1'b0;
    errSet   = 1'b0;
    errNxt   = errR;
    rdCap    = 1'b0;
    rdClr    = 1'b0;
    mergeCap = 1'b0;
    case (state)
      IDLE: begin
        if (code != MC_NONE) begin
          latchReq = 1'b1;
          cntClr   = 1'b1;
          if (decErr) begin
            stateNxt = RESP;
            errSet   = 1'b1;
            errNxt   = ERR_DECODE;
            rdClr    = 1'b1;
          end else if (alignErr) begin
            stateNxt = RESP;
            errSet   = 1'b1;
            errNxt   = ERR_ALIGN;
            rdClr    = 1'b1;
          end else if (code == MC_WR_BYTE) begin
            stateNxt = RMW_RD;
          end else if (code == MC_WR_WORD) begin
            stateNxt = WR_WAIT;
          end else begin
            stateNxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          rdCap    = 1'b1;
          stateNxt = RESP;
        end else begin
          cntInc = 1'b1;
        end
      end
      RMW_RD: begin
        if (mem_ack) begin
          mergeCap = 1'b1;
          cntClr   = 1'b1;
          stateNxt = RMW_WR;
        end else begin
          cntInc = 1'b1;
        end
      end
      RMW_WR, WR_WAIT: begin
        if (mem_ack) begin
          rdClr    = 1'b1;
          stateNxt = RESP;
        end else begin
          cntInc = 1'b1;
        end
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (tmo) begin
      stateNxt = RESP;
      errSet   = 1'b1;
      errNxt   = ERR_TIMEOUT;
      rdClr    = 1'b1;
      cntInc   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNxt;
  end

  byte_lane uLane (
    .word    (mem_rdata),
    .lane    (laneR),
    .signExt (codeR == MC_RD_BYTES),
    .wrByte  (byteR),
    .rdExt   (laneRd),
    .merged  (laneMerged)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      waitCnt <= 4'd0;
      addrR   <= '0;
      laneR   <= 3'd0;
      selR    <= 1'b0;
      codeR   <= MC_NONE;
      wdataR  <= 48'd0;
      byteR   <= 8'd0;
      rdR     <= 48'd0;
      errR    <= ERR_NONE;
      errPend <= 1'b0;
    end else begin
      if (latchReq) begin
        addrR  <= ALUOutM[WADDR_W+2:3];
        laneR  <= lane;
        selR   <= (region == IO_BASE);
        codeR  <= code;
        wdataR <= WriteDataM;
        byteR  <= WriteDataM[7:0];
      end
      if (cntClr)      waitCnt <= 4'd0;
      else if (cntInc) waitCnt <= waitCnt + 4'd1;
      if (mergeCap) wdataR <= laneMerged;
      if (rdCap)      rdR <= (codeR == MC_RD_WORD) ? mem_rdata : laneRd;
      else if (rdClr) rdR <= 48'd0;
      if (errSet) errR <= errNxt;
      errPend <= errSet;
    end
  end

  // Gated by Reset so the stall releases the instant reset asserts, even with a code still applied.
  assign StallMem  = Reset && ((state == IDLE) ? (code != MC_NONE) : (state != RESP));
  assign mem_req   = waitState;
  assign mem_we    = (state == RMW_WR) || (state == WR_WAIT);
  assign mem_sel   = selR;
  assign mem_addr  = addrR;
  assign mem_wdata = wdataR;
  assign ReadDataM = rdR;
  assign BusErr    = errPend;
  assign ErrCode   = errR;

endmodule
